// File: rtl/tlb_miss_arbiter_pkg.sv
// Shared types for the ITLB/DTLB miss arbiter in front of the shared TLB.
// Widths follow Sv39 on the 64-bit CVA6 configuration.
package tlb_miss_arbiter_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned VPN_W  = (XLEN == 64) ? 27 : 20;
  localparam int unsigned ASID_W = (XLEN == 64) ? 16 : 9;

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              is_inst;
  } tlb_miss_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tlb_miss_arbiter.sv
// Round-robin arbiter putting ITLB/DTLB misses onto the shared TLB lookup port,
// one miss in flight, with flush that drains a pending response silently.
module tlb_miss_arbiter
  import tlb_miss_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              itlb_miss_i,
  input  logic [VPN_W-1:0]  itlb_vpn_i,
  input  logic [ASID_W-1:0] itlb_asid_i,
  input  logic              dtlb_miss_i,
  input  logic [VPN_W-1:0]  dtlb_vpn_i,
  input  logic [ASID_W-1:0] dtlb_asid_i,
  output logic              itlb_grant_o,
  output logic              dtlb_grant_o,
  output logic              req_valid_o,
  output logic [VPN_W-1:0]  req_vpn_o,
  output logic [ASID_W-1:0] req_asid_o,
  output logic              req_is_inst_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  output logic              itlb_done_o,
  output logic              dtlb_done_o,
  output logic              busy_o
);

  arb_state_e    state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  tlb_miss_req_t req_q, req_d;
  logic          pick_dtlb;
  logic          capture;

  // 0 = ITLB side, 1 = DTLB side; rr_q breaks ties when both request
  always_comb begin
    if (itlb_miss_i && dtlb_miss_i) pick_dtlb = rr_q;
    else                            pick_dtlb = dtlb_miss_i;
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    req_d        = req_q;
    capture      = 1'b0;
    itlb_grant_o = 1'b0;
    dtlb_grant_o = 1'b0;
    itlb_done_o  = 1'b0;
    dtlb_done_o  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        capture = (itlb_miss_i || dtlb_miss_i) && !flush_i;
        if (capture) begin
          itlb_grant_o = !pick_dtlb;
          dtlb_grant_o = pick_dtlb;
          owner_d      = pick_dtlb;
          rr_d         = !pick_dtlb;
          req_d.vpn    = pick_dtlb ? dtlb_vpn_i  : itlb_vpn_i;
          req_d.asid   = pick_dtlb ? dtlb_asid_i : itlb_asid_i;
          req_d.is_inst = !pick_dtlb;
          state_d      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (flush_i)          state_d = ARB_IDLE;
        else if (req_ready_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (rsp_valid_i) begin
          // a flush landing on the response cycle still suppresses delivery
          itlb_done_o = !flush_i && !owner_q;
          dtlb_done_o = !flush_i && owner_q;
          state_d     = ARB_IDLE;
        end else if (flush_i) begin
          state_d = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (rsp_valid_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  assign req_valid_o   = (state_q == ARB_ISSUE);
  assign busy_o        = (state_q != ARB_IDLE);
  assign req_vpn_o     = req_q.vpn;
  assign req_asid_o    = req_q.asid;
  assign req_is_inst_o = req_q.is_inst;

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Directed bench for tlb_miss_arbiter: arbitration order, backpressure, flush/drain.
module tb_tlb_miss_arbiter;
  import tlb_miss_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              itlb_miss, dtlb_miss;
  logic [VPN_W-1:0]  itlb_vpn, dtlb_vpn;
  logic [ASID_W-1:0] itlb_asid, dtlb_asid;
  logic              itlb_grant, dtlb_grant;
  logic              req_valid;
  logic [VPN_W-1:0]  req_vpn;
  logic [ASID_W-1:0] req_asid;
  logic              req_is_inst;
  logic              req_ready, rsp_valid;
  logic              itlb_done, dtlb_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_miss_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .itlb_miss_i   (itlb_miss),
    .itlb_vpn_i    (itlb_vpn),
    .itlb_asid_i   (itlb_asid),
    .dtlb_miss_i   (dtlb_miss),
    .dtlb_vpn_i    (dtlb_vpn),
    .dtlb_asid_i   (dtlb_asid),
    .itlb_grant_o  (itlb_grant),
    .dtlb_grant_o  (dtlb_grant),
    .req_valid_o   (req_valid),
    .req_vpn_o     (req_vpn),
    .req_asid_o    (req_asid),
    .req_is_inst_o (req_is_inst),
    .req_ready_i   (req_ready),
    .rsp_valid_i   (rsp_valid),
    .itlb_done_o   (itlb_done),
    .dtlb_done_o   (dtlb_done),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after posedge; outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    itlb_miss = 1'b0; dtlb_miss = 1'b0;
    itlb_vpn = '0; dtlb_vpn = '0; itlb_asid = '0; dtlb_asid = '0;
    req_ready = 1'b0; rsp_valid = 1'b0;

    // reset values
    sample();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_vpn", 64'(req_vpn), 64'd0);
    chk("rst_is_inst", 64'(req_is_inst), 64'd0);
    chk("rst_done", 64'({itlb_done, dtlb_done}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single DTLB miss, minimum latency
    dtlb_miss = 1'b1; dtlb_vpn = 27'h1234; dtlb_asid = 16'h0055; req_ready = 1'b1;
    sample();
    chk("t1_c0_dgrant", 64'(dtlb_grant), 64'd1);
    chk("t1_c0_igrant", 64'(itlb_grant), 64'd0);
    chk("t1_c0_req_valid", 64'(req_valid), 64'd0);
    tick();
    sample();
    chk("t1_c1_req_valid", 64'(req_valid), 64'd1);
    chk("t1_c1_vpn", 64'(req_vpn), 64'h1234);
    chk("t1_c1_asid", 64'(req_asid), 64'h55);
    chk("t1_c1_is_inst", 64'(req_is_inst), 64'd0);
    chk("t1_c1_done", 64'(dtlb_done), 64'd0);
    tick();
    rsp_valid = 1'b1;
    sample();
    chk("t1_c2_ddone", 64'(dtlb_done), 64'd1);
    chk("t1_c2_idone", 64'(itlb_done), 64'd0);
    tick();
    dtlb_miss = 1'b0; rsp_valid = 1'b0;
    sample();
    chk("t1_c3_busy", 64'(busy), 64'd0);
    chk("t1_c3_dgrant", 64'(dtlb_grant), 64'd0);
    tick();

    // both request together: order alternates I, D, I, D
    for (int it = 0; it < 2; it++) begin
      itlb_miss = 1'b1; itlb_vpn = 27'(32'h0AA0 + it);
      dtlb_miss = 1'b1; dtlb_vpn = 27'(32'h0BB0 + it);
      sample();
      chk("t2_igrant_first", 64'(itlb_grant), 64'd1);
      chk("t2_dgrant_held", 64'(dtlb_grant), 64'd0);
      tick();
      sample();
      chk("t2_ivpn", 64'(req_vpn), 64'(32'h0AA0 + it));
      chk("t2_i_is_inst", 64'(req_is_inst), 64'd1);
      tick();
      rsp_valid = 1'b1;
      sample();
      chk("t2_idone", 64'(itlb_done), 64'd1);
      chk("t2_ddone_none", 64'(dtlb_done), 64'd0);
      tick();
      itlb_miss = 1'b0; rsp_valid = 1'b0;
      sample();
      chk("t2_dgrant_second", 64'(dtlb_grant), 64'd1);
      chk("t2_igrant_none", 64'(itlb_grant), 64'd0);
      tick();
      sample();
      chk("t2_dvpn", 64'(req_vpn), 64'(32'h0BB0 + it));
      chk("t2_d_is_inst", 64'(req_is_inst), 64'd0);
      tick();
      rsp_valid = 1'b1;
      sample();
      chk("t2_ddone", 64'(dtlb_done), 64'd1);
      tick();
      dtlb_miss = 1'b0; rsp_valid = 1'b0;
      sample();
      chk("t2_idle", 64'(busy), 64'd0);
      tick();
    end

    // backpressure: ready low 5 cycles, payload must not follow inputs
    itlb_miss = 1'b1; itlb_vpn = 27'h0077; itlb_asid = 16'h0009; req_ready = 1'b0;
    sample();
    chk("t3_igrant", 64'(itlb_grant), 64'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      itlb_vpn = 27'(32'h5000 + c); itlb_asid = 16'(32'h100 + c);
      sample();
      chk("t3_req_valid", 64'(req_valid), 64'd1);
      chk("t3_vpn_stable", 64'(req_vpn), 64'h77);
      chk("t3_asid_stable", 64'(req_asid), 64'h9);
      chk("t3_no_done", 64'(itlb_done), 64'd0);
      tick();
    end
    req_ready = 1'b1;
    sample();
    chk("t3_req_valid_acc", 64'(req_valid), 64'd1);
    tick();
    rsp_valid = 1'b1;
    sample();
    chk("t3_idone", 64'(itlb_done), 64'd1);
    tick();
    itlb_miss = 1'b0; rsp_valid = 1'b0;
    tick();

    // flush in WAIT, response arrives 3 cycles later and is dropped
    dtlb_miss = 1'b1; dtlb_vpn = 27'h0321;
    sample();
    chk("t4_dgrant", 64'(dtlb_grant), 64'd1);
    tick();
    tick();
    flush = 1'b1;
    sample();
    chk("t4_flush_done", 64'(dtlb_done), 64'd0);
    tick();
    flush = 1'b0; dtlb_miss = 1'b0;
    sample();
    chk("t4_drain", 64'(dut.state_q === ARB_DRAIN), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    tick();
    sample();
    chk("t4_drain2", 64'(dut.state_q === ARB_DRAIN), 64'd1);
    tick();
    rsp_valid = 1'b1;
    sample();
    chk("t4_rsp_dropped", 64'({itlb_done, dtlb_done}), 64'd0);
    chk("t4_busy_rsp", 64'(busy), 64'd1);
    tick();
    rsp_valid = 1'b0;
    sample();
    chk("t4_busy_after", 64'(busy), 64'd0);
    tick();

    // flush coincident with rsp in WAIT
    itlb_miss = 1'b1; itlb_vpn = 27'h0444;
    sample();
    chk("t5_igrant", 64'(itlb_grant), 64'd1);
    tick();
    tick();
    rsp_valid = 1'b1; flush = 1'b1;
    sample();
    chk("t5_done_suppressed", 64'({itlb_done, dtlb_done}), 64'd0);
    tick();
    rsp_valid = 1'b0; flush = 1'b0; itlb_miss = 1'b0;
    sample();
    chk("t5_idle", 64'(busy), 64'd0);
    tick();

    // flush in ISSUE withdraws the request
    dtlb_miss = 1'b1; req_ready = 1'b0;
    sample();
    chk("t5b_dgrant", 64'(dtlb_grant), 64'd1);
    tick();
    flush = 1'b1;
    sample();
    chk("t5b_req_valid", 64'(req_valid), 64'd1);
    tick();
    flush = 1'b0; dtlb_miss = 1'b0;
    sample();
    chk("t5b_req_withdrawn", 64'(req_valid), 64'd0);
    chk("t5b_idle", 64'(busy), 64'd0);
    tick();

    // flush in IDLE blocks capture
    itlb_miss = 1'b1; flush = 1'b1;
    sample();
    chk("t5c_blocked", 64'({itlb_grant, dtlb_grant}), 64'd0);
    tick();
    flush = 1'b0;
    sample();
    chk("t5c_igrant", 64'(itlb_grant), 64'd1);
    tick();
    req_ready = 1'b1;
    tick();
    rsp_valid = 1'b1;
    sample();
    chk("t5c_idone", 64'(itlb_done), 64'd1);
    tick();
    itlb_miss = 1'b0; rsp_valid = 1'b0;
    tick();

    // stray response in IDLE
    rsp_valid = 1'b1;
    sample();
    chk("t6_no_done", 64'({itlb_done, dtlb_done}), 64'd0);
    tick();
    rsp_valid = 1'b0;
    sample();
    chk("t6_idle", 64'(busy), 64'd0);
    tick();

    // asynchronous reset mid-request
    dtlb_miss = 1'b1; dtlb_vpn = 27'h0ABC; req_ready = 1'b0;
    sample();
    chk("t7_dgrant", 64'(dtlb_grant), 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req_valid", 64'(req_valid), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_vpn", 64'(req_vpn), 64'd0);
    dtlb_miss = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_miss_arbiter.md
# tlb_miss_arbiter

Arbitrates ITLB and DTLB misses onto the single lookup port of the shared TLB (64 entries, in front of the PTW) in the MMU. Accepts one miss at a time with two-way round-robin fairness, holds the winning request until the shared TLB accepts it, and routes the completion back to the originating L1 TLB. Supports flush with in-flight drain, so a stale response is never delivered to a new request.

## Interface
- VPN_W, 27, virtual page number width (Sv39)
- ASID_W, 16, address-space identifier width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  sfence/context-switch flush; aborts current miss
- itlb_miss_i  in  1  ITLB miss request; held until itlb_done_o or flush
- itlb_vpn_i  in  VPN_W  ITLB miss VPN
- itlb_asid_i  in  ASID_W  ITLB miss ASID
- dtlb_miss_i  in  1  DTLB miss request; held until dtlb_done_o or flush
- dtlb_vpn_i  in  VPN_W  DTLB miss VPN
- dtlb_asid_i  in  ASID_W  DTLB miss ASID
- itlb_grant_o / dtlb_grant_o  out  1  one-cycle pulse: miss captured
- req_valid_o  out  1  lookup request to shared TLB
- req_vpn_o  out  VPN_W  captured VPN
- req_asid_o  out  ASID_W  captured ASID
- req_is_inst_o  out  1  1 = ITLB owner (execute permission check)
- req_ready_i  in  1  shared TLB accepts request
- rsp_valid_i  in  1  shared TLB finished lookup (hit or PTW complete)
- itlb_done_o / dtlb_done_o  out  1  one-cycle completion pulse to owner
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: if any miss and !flush_i, pick winner; capture vpn/asid/is_inst into registers; pulse winner's grant (combinational, same cycle); set owner; go ISSUE. Flip rr pointer to the loser side.
- Pick: only one requesting -> it wins; both -> side indicated by rr_q (0 = ITLB, 1 = DTLB).
- ISSUE: req_valid_o = 1; req_valid_o && req_ready_i -> WAIT. flush_i -> IDLE (request withdrawn, no done).
- WAIT: rsp_valid_i -> owner's done pulse (combinational), go IDLE. flush_i without rsp_valid_i -> DRAIN. flush_i with rsp_valid_i -> IDLE, done suppressed.
- DRAIN: wait for rsp_valid_i, drop it (no done), go IDLE. flush_i in DRAIN: ignored (stay).
- rsp_valid_i in IDLE/ISSUE: ignored.
- flush_i in IDLE blocks capture that cycle.
- Payload registers load only on capture; stable through ISSUE/WAIT.

## Timing
- Reset: state IDLE, rr_q = 0, owner = 0, req_vpn_o/req_asid_o/req_is_inst_o = 0; all valid/grant/done/busy outputs 0.
- Grant pulse in the capture cycle; req_valid_o asserted from the next cycle.
- Minimum miss-to-done: capture (cycle 0), ISSUE with ready (cycle 1), rsp_valid_i (cycle 2) -> done at cycle 2.
- After done, state IDLE next cycle; next capture possible that cycle (one request in flight max).
- Requester drops miss the cycle after its done; a miss still high in IDLE is a new request.
- Reset mid-operation: immediate return to reset values; in-flight shared-TLB request is reset by the same rst_ni.

## Structure
- tlb_miss_req_t {vpn, asid, is_inst} and the arbiter state enum belong in the shared MMU package alongside the TLB typedefs; VPN_W/ASID_W derived there from the CVA6 config (XLEN 64 -> Sv39).
- Single module; two-input round-robin is inline logic, no sub-module.

## Test plan
- Only dtlb_miss_i, vpn 0x1234, ready immediate, rsp 1 cycle later -> dtlb_grant_o at c0, req_valid_o c1 with vpn 0x1234, is_inst 0, dtlb_done_o c2.
- Both misses together from reset -> ITLB granted first (rr_q = 0), DTLB granted in the IDLE cycle after itlb_done_o; repeat twice -> order alternates I, D, I, D.
- req_ready_i held low 5 cycles -> req_valid_o and payload stable for 5 cycles, no done.
- flush_i in WAIT, rsp_valid_i 3 cycles later -> state DRAIN, no done pulse, busy_o drops the cycle after rsp_valid_i.
- flush_i coincident with rsp_valid_i in WAIT -> no done, IDLE next cycle; flush_i in ISSUE -> req_valid_o low next cycle.
- rsp_valid_i pulsed in IDLE -> no done, state unchanged.
